// File: rtl/jug_pour_engine_if.sv
// Command handshake bundle for jug_pour_engine.
//   cmd_valid : command offered by the requester
//   cmd_ready : engine can accept a command this cycle
//   cmd_src   : source bucket (0=A, 1=B, 2=C, 3=illegal)
//   cmd_dst   : destination bucket, same encoding
// master = command issuer, slave = engine.
interface jug_pour_engine_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_src;
  logic [1:0] cmd_dst;

  modport master (output cmd_valid, output cmd_src, output cmd_dst, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_src, input cmd_dst, output cmd_ready);
endinterface

// File: rtl/jug_pour_engine.sv
// Three-bucket water-jug engine. Accepts pour commands over a valid/ready
// handshake and moves one unit of water per clock from the source bucket to
// the destination bucket until the source is empty or the destination is full.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   cmd_if (slave)  : command handshake (valid/ready/src/dst)
//   bkt_a/b/c_o     : registered bucket levels
//   busy_o          : engine is in POUR or DONE
//   cmd_done_o      : one-cycle pulse, accepted legal command finished
//   err_o           : one-cycle pulse, illegal command rejected
//   move_count_o    : completed legal moves, saturating at 0xFFFF
//   goal_hit_o      : combinational, some bucket holds GOAL
//   goal_seen_o     : sticky, goal_hit has been seen since reset
module jug_pour_engine #(
  parameter int unsigned CAP_A = 8,
  parameter int unsigned CAP_B = 5,
  parameter int unsigned CAP_C = 3,
  parameter int unsigned GOAL  = 4,
  parameter int unsigned W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  jug_pour_engine_if.slave     cmd_if,
  output logic [W-1:0]         bkt_a_o,
  output logic [W-1:0]         bkt_b_o,
  output logic [W-1:0]         bkt_c_o,
  output logic                 busy_o,
  output logic                 cmd_done_o,
  output logic                 err_o,
  output logic [15:0]          move_count_o,
  output logic                 goal_hit_o,
  output logic                 goal_seen_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, POUR = 2'd1, DONE = 2'd2} state_e;

  localparam logic [W-1:0] ONE_W  = W'(1);
  localparam logic [W-1:0] ZERO_W = {W{1'b0}};
  localparam logic [W-1:0] CAP_AW = W'(CAP_A);
  localparam logic [W-1:0] CAP_BW = W'(CAP_B);
  localparam logic [W-1:0] CAP_CW = W'(CAP_C);
  localparam logic [W-1:0] GOAL_W = W'(GOAL);

  // Selects one of three bucket-indexed values; code 3 yields zero.
  function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [W-1:0] c);
    case (sel)
      2'd0:    pick = a;
      2'd1:    pick = b;
      2'd2:    pick = c;
      default: pick = ZERO_W;
    endcase
  endfunction

  // One unit of transfer applied to the bucket with index idx.
  function automatic logic [W-1:0] pour_step(input logic [1:0] idx, input logic [1:0] src,
                                             input logic [1:0] dst, input logic [W-1:0] lvl);
    if (idx == src) begin
      pour_step = lvl - ONE_W;
    end else if (idx == dst) begin
      pour_step = lvl + ONE_W;
    end else begin
      pour_step = lvl;
    end
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  src_q, src_d, dst_q, dst_d;
  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [15:0] mc_q, mc_d;
  logic        err_q, err_d;
  logic        goal_seen_q, goal_seen_d;

  logic        accept_s, illegal_s, goal_hit_s;
  logic [W-1:0] src_lvl_s, dst_lvl_s, dst_cap_s, space_s, amt_s;
  logic [15:0] mc_inc_s;

  assign cmd_if.cmd_ready = (state_q == IDLE) && !rst;
  assign accept_s  = cmd_if.cmd_valid && cmd_if.cmd_ready;
  assign illegal_s = (cmd_if.cmd_src == 2'd3) || (cmd_if.cmd_dst == 2'd3) ||
                     (cmd_if.cmd_src == cmd_if.cmd_dst);

  // Transfer amount: destination headroom never wraps since levels never exceed capacity.
  assign src_lvl_s = pick(cmd_if.cmd_src, a_q, b_q, c_q);
  assign dst_lvl_s = pick(cmd_if.cmd_dst, a_q, b_q, c_q);
  assign dst_cap_s = pick(cmd_if.cmd_dst, CAP_AW, CAP_BW, CAP_CW);
  assign space_s   = dst_cap_s - dst_lvl_s;
  assign amt_s     = (src_lvl_s < space_s) ? src_lvl_s : space_s;

  assign mc_inc_s   = (mc_q == 16'hFFFF) ? mc_q : (mc_q + 16'd1);
  assign goal_hit_s = (a_q == GOAL_W) || (b_q == GOAL_W) || (c_q == GOAL_W);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= 2'd0;
      dst_q       <= 2'd0;
      rem_q       <= ZERO_W;
      a_q         <= CAP_AW;
      b_q         <= ZERO_W;
      c_q         <= ZERO_W;
      mc_q        <= 16'd0;
      err_q       <= 1'b0;
      goal_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      mc_q        <= mc_d;
      err_q       <= err_d;
      goal_seen_q <= goal_seen_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    mc_d        = mc_q;
    err_d       = 1'b0;
    goal_seen_d = goal_seen_q | goal_hit_s;
    case (state_q)
      IDLE: begin
        if (accept_s && illegal_s) begin
          err_d = 1'b1;
        end else if (accept_s) begin
          src_d = cmd_if.cmd_src;
          dst_d = cmd_if.cmd_dst;
          rem_d = amt_s;
          if (amt_s == ZERO_W) begin
            // Nothing to move, but it still counts as a completed move.
            state_d = DONE;
            mc_d    = mc_inc_s;
          end else begin
            state_d = POUR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      POUR: begin
        a_d   = pour_step(2'd0, src_q, dst_q, a_q);
        b_d   = pour_step(2'd1, src_q, dst_q, b_q);
        c_d   = pour_step(2'd2, src_q, dst_q, c_q);
        rem_d = rem_q - ONE_W;
        if (rem_q == ONE_W) begin
          state_d = DONE;
          mc_d    = mc_inc_s;
        end else begin
          state_d = POUR;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bkt_a_o      = a_q;
  assign bkt_b_o      = b_q;
  assign bkt_c_o      = c_q;
  assign busy_o       = (state_q == POUR) || (state_q == DONE);
  assign cmd_done_o   = (state_q == DONE);
  assign err_o        = err_q;
  assign move_count_o = mc_q;
  assign goal_hit_o   = goal_hit_s;
  assign goal_seen_o  = goal_seen_q;

endmodule
